// File: rtl/sprinkler_pkg.sv
// Shared types and helpers for the sprinkler zone sequencer.
// Zone selection helpers keep the zone-stepping rules in one place.
package sprinkler_pkg;

    localparam int NUM_ZONES = 4;
    localparam int ZONE_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              found;
        logic [ZONE_W-1:0] idx;
    } zone_hit_t;

    function automatic logic [NUM_ZONES-1:0] onehot4(
        input logic [ZONE_W-1:0] sel
    );
        return 4'b0001 << sel;
    endfunction

    // Next enabled zone strictly above cur; descending scan so the lowest wins.
    function automatic zone_hit_t next_zone(
        input logic [NUM_ZONES-1:0] mask,
        input logic [ZONE_W-1:0]    cur
    );
        zone_hit_t r;
        r = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (mask[i] && (ZONE_W'(i) > cur)) begin
                r.found = 1'b1;
                r.idx   = ZONE_W'(i);
            end
        end
        return r;
    endfunction

    function automatic zone_hit_t first_zone(
        input logic [NUM_ZONES-1:0] mask
    );
        zone_hit_t r;
        r = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = ZONE_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprinkler_zone_sequencer_tick_prescaler.sv
// Free-running divider that pulses tick on the last of every TICK_DIV
// enabled cycles; clr restarts the count from zero.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/sprinkler_zone_sequencer.sv
// Steps enabled sprinkler zones in ascending order, one valve at a time,
// with an all-closed gap between zones and a start/abort/busy/done handshake.
module sprinkler_zone_sequencer
    import sprinkler_pkg::*;
#(
    parameter int TIME_W     = 8,
    parameter int TICK_DIV   = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        zone_en,
    input  logic [TIME_W-1:0] run_time,
    output logic [1:0]        sel,
    output logic [3:0]        valve,
    output logic              busy,
    output logic              done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t state_q;
    state_t state_d;

    logic [NUM_ZONES-1:0] mask_q;
    logic [TIME_W-1:0]    run_q;
    logic [TIME_W-1:0]    tick_cnt;
    logic [GW-1:0]        gap_cnt;

    logic [ZONE_W-1:0]    sel_d;
    logic [3:0]           valve_d;
    logic                 busy_d;
    logic                 done_d;

    logic      in_run;
    logic      tick;
    logic      last_tick;
    logic      gap_end;
    logic      accept;
    zone_hit_t first;
    zone_hit_t nxt;

    assign in_run    = (state_q == RUN);
    assign last_tick = tick && (tick_cnt == run_q - TIME_W'(1));
    assign gap_end   = (state_q == GAP) && (gap_cnt == GAP_LAST);
    assign accept    = (state_q == IDLE) && start && !abort;
    assign first     = first_zone(zone_en);
    assign nxt       = next_zone(mask_q, sel);

    // Cleared whenever not running so every RUN entry starts a fresh tick.
    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (!in_run),
        .en  (in_run),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst || !in_run) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state_q != GAP)) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel     <= '0;
            valve   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mask_q  <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            valve   <= valve_d;
            busy    <= busy_d;
            done    <= done_d;
            if (accept) begin
                mask_q <= zone_en;
                run_q  <= run_time;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        valve_d = valve;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!first.found || (run_time == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        sel_d   = first.idx;
                        valve_d = onehot4(first.idx);
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    valve_d = '0;
                    busy_d  = 1'b0;
                end else if (last_tick) begin
                    valve_d = '0;
                    if (nxt.found) begin
                        // Move the mux select now so it settles during the gap.
                        state_d = GAP;
                        sel_d   = nxt.idx;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    valve_d = '0;
                    busy_d  = 1'b0;
                end else if (gap_end) begin
                    state_d = RUN;
                    valve_d = onehot4(sel);
                end
            end
            default: begin
                state_d = IDLE;
                valve_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sprinkler_zone_sequencer.sv
// Directed table-driven bench for the sprinkler zone sequencer,
// with hand-written abort, busy-start and reset-in-gap sequences.
module tb_sprinkler_zone_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] zone_en;
    logic [7:0] run_time;
    logic [1:0] sel;
    logic [3:0] valve;
    logic       busy;
    logic       done;

    int total = 0;
    int passed = 0;

    typedef struct packed {
        logic [3:0]  v;
        logic [1:0]  s;
        logic [15:0] n;
    } run_t;

    typedef struct {
        logic [3:0] zone_en;
        logic [7:0] run_time;
        int         done_at;
        int         busy_cyc;
        int         nruns;
        run_t [7:0] runs;
    } vec_t;

    vec_t vecs[8];

    sprinkler_zone_sequencer #(
        .TIME_W    (8),
        .TICK_DIV  (2),
        .GAP_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .zone_en (zone_en),
        .run_time(run_time),
        .sel     (sel),
        .valve   (valve),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic ok;
        ok = 1'b1;
        if ((valve & (valve - 4'd1)) != 4'd0) ok = 1'b0;
        if (valve != 4'd0 && valve != (4'b0001 << sel)) ok = 1'b0;
        if (!busy && valve != 4'd0) ok = 1'b0;
        if (done && busy) ok = 1'b0;
        total++;
        if (ok) passed++;
        else $display("FAIL invariant: t=%0t valve=%b sel=%0d busy=%b done=%b",
                      $time, valve, sel, busy, done);
    end

    task automatic set_vec(input int i, input logic [3:0] ze, input logic [7:0] rt,
                           input int dat, input int bc);
        vecs[i].zone_en  = ze;
        vecs[i].run_time = rt;
        vecs[i].done_at  = dat;
        vecs[i].busy_cyc = bc;
        vecs[i].nruns    = 0;
        vecs[i].runs     = '0;
    endtask

    task automatic add_run(input int i, input logic [3:0] v, input logic [1:0] s,
                           input int n);
        vecs[i].runs[vecs[i].nruns] = '{v, s, 16'(n)};
        vecs[i].nruns++;
    endtask

    task automatic run_vec(input int idx, input bit disturb);
        vec_t v;
        run_t q[$];
        run_t r;
        int   dat;
        int   bcnt;
        v    = vecs[idx];
        dat  = -1;
        bcnt = 0;
        @(posedge clk); #1;
        zone_en  = v.zone_en;
        run_time = v.run_time;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 2000 && dat < 0; c++) begin
            @(negedge clk);
            if (disturb && c == 3) begin
                start    = 1'b1;
                zone_en  = 4'hf;
                run_time = 8'd1;
            end
            if (disturb && c == 4) start = 1'b0;
            if (done) begin
                dat = c;
            end else begin
                if (busy) bcnt++;
                if (busy || valve != 4'd0) begin
                    if (q.size() == 0 || q[q.size()-1].v != valve ||
                        q[q.size()-1].s != sel) begin
                        q.push_back('{valve, sel, 16'd1});
                    end else begin
                        r = q[q.size()-1];
                        r.n++;
                        q[q.size()-1] = r;
                    end
                end
            end
        end
        chk($sformatf("v%0d done_at", idx), dat, v.done_at);
        chk($sformatf("v%0d busy_cycles", idx), bcnt, v.busy_cyc);
        chk($sformatf("v%0d run_count", idx), q.size(), v.nruns);
        for (int k = 0; k < v.nruns && k < q.size(); k++)
            chk($sformatf("v%0d run%0d {valve,sel,len}", idx, k),
                int'(q[k]), int'(v.runs[k]));
        @(negedge clk);
        chk($sformatf("v%0d done_width", idx), int'(done), 0);
        chk($sformatf("v%0d busy_after", idx), int'(busy), 0);
    endtask

    initial begin
        int dcnt;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        zone_en  = 4'd0;
        run_time = 8'd0;

        set_vec(0, 4'b1111, 8'd3, 37, 36);
        add_run(0, 4'b0001, 2'd0, 6);
        add_run(0, 4'b0000, 2'd1, 4);
        add_run(0, 4'b0010, 2'd1, 6);
        add_run(0, 4'b0000, 2'd2, 4);
        add_run(0, 4'b0100, 2'd2, 6);
        add_run(0, 4'b0000, 2'd3, 4);
        add_run(0, 4'b1000, 2'd3, 6);
        set_vec(1, 4'b1010, 8'd2, 13, 12);
        add_run(1, 4'b0010, 2'd1, 4);
        add_run(1, 4'b0000, 2'd3, 4);
        add_run(1, 4'b1000, 2'd3, 4);
        set_vec(2, 4'b0000, 8'd5, 1, 0);
        set_vec(3, 4'b1111, 8'd0, 1, 0);
        set_vec(4, 4'b0100, 8'd1, 3, 2);
        add_run(4, 4'b0100, 2'd2, 2);
        set_vec(5, 4'b1001, 8'd4, 21, 20);
        add_run(5, 4'b0001, 2'd0, 8);
        add_run(5, 4'b0000, 2'd3, 4);
        add_run(5, 4'b1000, 2'd3, 8);
        set_vec(6, 4'b0110, 8'd1, 9, 8);
        add_run(6, 4'b0010, 2'd1, 2);
        add_run(6, 4'b0000, 2'd2, 4);
        add_run(6, 4'b0100, 2'd2, 2);
        set_vec(7, 4'b0001, 8'd255, 511, 510);
        add_run(7, 4'b0001, 2'd0, 510);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset sel", int'(sel), 0);
        chk("reset valve", int'(valve), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);

        for (int i = 0; i < 8; i++) run_vec(i, 1'b0);

        // Abort during zone 2 RUN.
        @(posedge clk); #1;
        zone_en  = 4'b1111;
        run_time = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (22) @(negedge clk);
        chk("abort pre valve", int'(valve), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort valve", int'(valve), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort sel hold", int'(sel), 2);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        chk("no done after abort", dcnt, 0);
        run_vec(1, 1'b0);

        // Start and input changes while busy are ignored.
        run_vec(1, 1'b1);

        // start together with abort in IDLE.
        @(posedge clk); #1;
        zone_en  = 4'b1111;
        run_time = 8'd3;
        start    = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start+abort busy", int'(busy), 0);
        chk("start+abort done", int'(done), 0);
        repeat (3) @(negedge clk);
        chk("start+abort valve", int'(valve), 0);

        // Reset during a GAP.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("gap sel before rst", int'(sel), 1);
        chk("gap busy before rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst sel", int'(sel), 0);
        chk("rst valve", int'(valve), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        @(negedge clk);
        chk("rst stays idle", int'(busy), 0);
        run_vec(4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
